// File: rtl/cpu_pio_pkg.sv
// Shared constants for the input-capture PIO.
// Register map, edge encodings and arm terminal count.
package cpu_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/cpu_pio_edge_bit.sv
// One input bit: 2-flop synchroniser, history flop
// and gated edge detect.
module cpu_pio_edge_bit
  import cpu_pio_pkg::*;
#(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  input  logic i_arm,
  output logic o_s2,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_h;
  logic w_det;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_h  <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_h  <= r_s2;
    end
  end

  always_comb begin
    w_det = 1'b0;
    if (EDGE_TYPE == EDGE_FALL)
      w_det = ~r_s2 & r_h;
    else if (EDGE_TYPE == EDGE_ANY)
      w_det = r_s2 ^ r_h;
    else
      w_det = r_s2 & ~r_h;
  end

  assign o_s2   = r_s2;
  assign o_edge = i_arm & w_det;

endmodule

// File: rtl/cpu_pio_in_capture.sv
// Avalon-MM input PIO with per-bit edge capture
// and a maskable level interrupt.
module cpu_pio_in_capture
  import cpu_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_EN    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [1:0]       r_arm;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_armed;
  logic             w_wr;
  logic             w_rd;
  logic             w_unused;

  assign w_armed  = (r_arm == ARM_DONE);
  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & write_n;
  assign w_unused = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    cpu_pio_edge_bit #(
      .EDGE_TYPE(EDGE_TYPE)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .i_pin  (in_port[g]),
      .i_arm  (w_armed),
      .o_s2   (w_s2[g]),
      .o_edge (w_edge[g])
    );
  end

  // W1C mask; a same-cycle edge is OR'd back in so set wins
  assign w_clr = (w_wr && address == ADDR_EDGE)
               ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      address == ADDR_DATA: w_rdata[WIDTH-1:0] = w_s2;
      address == ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
      address == ADDR_EDGE: w_rdata[WIDTH-1:0] = r_cap;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_arm    <= '0;
      r_cap    <= '0;
      r_mask   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (!w_armed)
        r_arm <= r_arm + 2'd1;
      r_cap <= (r_cap & ~w_clr) | w_edge;
      if (IRQ_EN != 0 && w_wr && address == ADDR_MASK)
        r_mask <= writedata[WIDTH-1:0];
      if (w_rd)
        readdata <= w_rdata;
      irq <= (IRQ_EN != 0) && (|(r_cap & r_mask));
    end
  end

endmodule

// File: tb/tb_cpu_pio_in_capture.sv
// Scoreboard bench for cpu_pio_in_capture: one
// rising-edge instance and one any-edge instance.
module tb_cpu_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_rise;
  logic [7:0]  in_any;
  logic [31:0] rd_rise;
  logic [31:0] rd_any;
  logic        irq_rise;
  logic        irq_any;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] q_exp[$];
  bit          q_sel[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  cpu_pio_in_capture #(
    .WIDTH(8), .EDGE_TYPE(0), .IRQ_EN(1)
  ) u_rise (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_rise),
    .readdata  (rd_rise),
    .irq       (irq_rise)
  );

  cpu_pio_in_capture #(
    .WIDTH(8), .EDGE_TYPE(2), .IRQ_EN(1)
  ) u_any (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_any),
    .readdata  (rd_any),
    .irq       (irq_any)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Callers are always at a negedge on entry.
  task automatic bus_write(input logic [1:0] a,
                           input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input string tag,
                          input bit sel,
                          input logic [1:0] a,
                          input logic [31:0] exp);
    q_exp.push_back(exp);
    q_sel.push_back(sel);
    q_tag.push_back(tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin : monitor
    bit          pend;
    logic [31:0] e;
    bit          s;
    string       t;
    forever begin
      @(posedge clk);
      pend = chipselect && write_n && reset_n;
      @(negedge clk);
      if (pend) begin
        if (q_exp.size() == 0) begin
          check("sb_empty", q_exp.size(), 1);
        end else begin
          e = q_exp.pop_front();
          s = q_sel.pop_front();
          t = q_tag.pop_front();
          check(t, s ? rd_any : rd_rise, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_rise    = 8'hFF;
    in_any     = 8'h00;
    tick(3);

    check("rst_rd", rd_rise, 32'h0);
    check("rst_irq", irq_rise, 1'b0);
    reset_n = 1'b1;
    tick(10);
    bus_read("t1_cap", 0, 2'd3, 32'h0);
    check("t1_irq", irq_rise, 1'b0);
    bus_read("t1_data", 0, 2'd0, 32'hFF);
    bus_read("t1_resv", 0, 2'd1, 32'h0);
    bus_write(2'd0, 32'h55);
    bus_read("t1_dataw", 0, 2'd0, 32'hFF);

    bus_write(2'd2, 32'h01);
    bus_read("t2_mask", 0, 2'd2, 32'h01);
    in_rise = 8'h00;
    tick(6);
    bus_read("t2_nofall", 0, 2'd3, 32'h0);
    in_rise = 8'h01;
    tick(3);
    check("t2_irq_lo", irq_rise, 1'b0);
    tick(1);
    check("t2_irq_hi", irq_rise, 1'b1);
    bus_read("t2_cap", 0, 2'd3, 32'h01);
    bus_write(2'd3, 32'h01);
    check("t2_irq_w", irq_rise, 1'b1);
    tick(1);
    check("t2_irq_clr", irq_rise, 1'b0);
    bus_read("t2_capclr", 0, 2'd3, 32'h0);

    bus_write(2'd2, 32'h00);
    in_rise = 8'h09;
    tick(3);
    in_rise = 8'h01;
    tick(5);
    bus_read("t3_cap", 0, 2'd3, 32'h08);
    check("t3_irq_m0", irq_rise, 1'b0);
    bus_write(2'd2, 32'h08);
    check("t3_irq_w", irq_rise, 1'b0);
    tick(1);
    check("t3_irq_hi", irq_rise, 1'b1);

    bus_write(2'd2, 32'h0C);
    in_rise = 8'h05;
    tick(2);
    bus_write(2'd3, 32'h04);
    check("t4_irq_a", irq_rise, 1'b1);
    tick(1);
    check("t4_irq_b", irq_rise, 1'b1);
    bus_read("t4_setwin", 0, 2'd3, 32'h0C);
    in_rise = 8'h15;
    tick(2);
    bus_read("t4_rd_old", 0, 2'd3, 32'h0C);
    bus_read("t4_rd_new", 0, 2'd3, 32'h1C);

    in_any = 8'h20;
    tick(4);
    bus_read("t5_up", 1, 2'd3, 32'h20);
    bus_write(2'd3, 32'h20);
    bus_read("t5_clr", 1, 2'd3, 32'h0);
    in_any = 8'h00;
    tick(4);
    bus_read("t5_down", 1, 2'd3, 32'h20);
    bus_write(2'd3, 32'h00);
    bus_read("t5_w0", 1, 2'd3, 32'h20);
    bus_read("t5_rise_w0", 0, 2'd3, 32'h1C);

    in_rise = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFF);
    bus_read("t6_clr", 0, 2'd3, 32'h0);
    in_rise = 8'hA5;
    tick(5);
    bus_write(2'd2, 32'hFF);
    tick(1);
    check("t6_irq_pre", irq_rise, 1'b1);
    bus_read("t6_cap", 0, 2'd3, 32'hA5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("t6_rst_rd", rd_rise, 32'h0);
    check("t6_rst_irq", irq_rise, 1'b0);
    bus_read("t6_mask", 0, 2'd2, 32'h0);
    bus_read("t6_arm_a", 0, 2'd3, 32'h0);
    tick(5);
    bus_read("t6_arm_b", 0, 2'd3, 32'h0);
    bus_read("t6_data", 0, 2'd0, 32'hA5);
    check("t6_irq_end", irq_rise, 1'b0);

    tick(2);
    check("sb_drain", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_pio_in_capture.md
Name: cpu_pio_in_capture

Overview:
Avalon-MM slave input PIO, the read-direction counterpart of the existing 8-bit output PIOs on the Nios system bus. It samples an external WIDTH-bit port through a 2-flop synchroniser. It latches selected edges into a per-bit capture register and raises a maskable level interrupt to the CPU. Software reads the live value, edge captures and mask over a 4-word register map.

Parameters:
WIDTH, 8, width of in_port (1..32)
EDGE_TYPE, 0, capture edge: 0 = rising, 1 = falling, 2 = any
IRQ_EN, 1, 0 ties irq low and makes the mask register read 0

Ports:
clk  input  1  system clock; one clock domain, all logic on its rising edge
reset_n  input  1  reset, synchronous, active-low
address  input  2  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data, bits [WIDTH-1:0] used
in_port  input  WIDTH  asynchronous external inputs
readdata  output  32  registered read data, zero-extended above WIDTH
irq  output  1  level interrupt to the CPU

Behaviour:
- Reset: sync flops, history, edge_capture, irq_mask, readdata, irq and arm counter all clear to 0 on a clk edge with reset_n=0. Reset asserted mid-operation wipes pending captures on that edge.
- Synchroniser: in_port -> s1 -> s2, so s2 lags the pin by 2 clk. A history register h holds s2 delayed by 1 clk.
- Arming: a 2-bit counter counts 0->3 after reset release and saturates at 3. Edge detection is suppressed while the counter is below 3. Pins already high at reset therefore produce no spurious rising edge.
- Edge, per bit i: rising = s2 & ~h; falling = ~s2 & h; any = s2 ^ h.
  - A detected edge sets edge_capture[i] on the next clk.
  - Worst-case capture latency from pin to capture bit is 4 clk.
- Register map, accessed when chipselect=1:
  - 0 DATA: read returns s2; writes are ignored.
  - 1 reserved: reads 0; writes are ignored.
  - 2 IRQ_MASK: read/write on bits [WIDTH-1:0].
  - 3 EDGE_CAP: read returns the captures; a write clears every bit where writedata[i]=1 (write-1-to-clear).
- Write timing: a write with chipselect & ~write_n takes effect on the same clk edge.
- Read timing: readdata is registered. When chipselect & write_n, readdata updates on the next clk edge (read latency 1). Otherwise readdata holds its value.
- Read value for the selected address: bits [31:WIDTH] are always 0. An address-0 read reflects s2 at the request edge.
- Simultaneous edge and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- Simultaneous read of EDGE_CAP and an edge in the same cycle: readdata returns the pre-update value, and the new capture is visible on the next read.
- irq = registered |(edge_capture & irq_mask).
  - irq asserts 1 clk after the capture bit or mask bit goes high.
  - irq deasserts 1 clk after the clear.
- No waitrequest: every access completes in fixed timing.

Decomposition:
- Shared package cpu_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3;
  - edge-type encoding constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2;
  - the arm-count terminal value 3.
- One sub-module, cpu_pio_edge_bit, is instantiated WIDTH times via generate. It contains the sync flops, history flop and edge detect for one bit, and outputs s2 and an edge pulse.
- The top level owns the register map, arming counter, readdata register and irq register.

Test Plan:
1. Reset with in_port=8'hFF held, release, wait 10 clk, read addr 3 -> readdata 0 and irq 0. Read addr 0 -> 8'hFF, returned 1 clk after the request.
2. EDGE_TYPE=0, write mask 8'h01, drive in_port[0] 0->1 -> edge_capture[0]=1 within 4 clk and irq=1 one clk later. Write addr 3 data 8'h01 -> irq=0 one clk after the write.
3. Pulse in_port[3] high for 3 clk with mask=0 -> capture 8'h08 and irq stays 0. Write mask 8'h08 -> irq asserts 1 clk after the write.
4. A W1C write of 8'h04 lands in the same cycle as a new bit-2 edge -> bit 2 remains 1 and irq stays asserted.
5. EDGE_TYPE=2, toggle bit 5 up then down, clearing in between -> two separate captures. Writing 8'h00 to addr 3 clears nothing.
6. Assert reset_n=0 for 1 clk while captures=8'hA5 and mask=8'hFF -> next clk: captures 0, mask 0, irq 0, readdata 0. No edge is captured during the 3-clk arming window.
